// File: rtl/rv_fetch_unit_pkg.sv
// Shared fetch-unit types and constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rv_fetch_unit_pkg;

  // Bytes per instruction word; the sequential PC step.
  localparam int INST_BYTES = 4;

  localparam int ADDR_WIDTH_DEFAULT = 32;
  localparam int INST_WIDTH_DEFAULT = 32;

  // First fetch address after reset for the default configuration.
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // One prefetch buffer entry at the default widths: PC in the upper bits.
  typedef struct packed {
    logic [ADDR_WIDTH_DEFAULT-1:0] pc;
    logic [INST_WIDTH_DEFAULT-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/rv_fetch_unit_if.sv
// Bundles the fetch unit's memory, redirect and decode channels.
// Latency: n/a (wires only).
// Backpressure: valid/ready on request and decode channels; response has none.
interface rv_fetch_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32
);
  logic                  imem_req_valid;
  logic                  imem_req_ready;
  logic [ADDR_WIDTH-1:0] imem_req_addr;
  logic                  imem_rsp_valid;
  logic [INST_WIDTH-1:0] imem_rsp_inst;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] out_pc;
  logic [INST_WIDTH-1:0] out_inst;
  logic                  err_rsp;

  // Fetch unit side.
  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_inst,
    input  redirect_valid, redirect_pc,
    output out_valid, out_pc, out_inst,
    input  out_ready,
    output err_rsp
  );

  // Memory / decode / branch-unit side.
  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_inst,
    output redirect_valid, redirect_pc,
    input  out_valid, out_pc, out_inst,
    output out_ready,
    input  err_rsp
  );
endinterface

// File: rtl/rv_fetch_unit_fetch_fifo.sv
// Synchronous FIFO with flush; head read combinationally from storage.
// Latency: a push is visible at the head the cycle after the write edge.
// Backpressure: push ignored when full unless a pop frees a slot the same cycle.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_dat,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign count   = count_q;
  assign pop_dat = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Next pointers, occupancy and storage; flush wins over push and pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

  // State registers; storage contents need no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/rv_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues in-order fetches, buffers results for decode.
// Latency: request the cycle after reset release; response at edge E appears on out_* the cycle after E.
// Backpressure: requests throttled so live in-flight plus buffered never exceeds FIFO_DEPTH.
module rv_fetch_unit
  import rv_fetch_unit_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    INST_WIDTH = 32,
  parameter int                    FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  rv_fetch_unit_if.master bus
);
  localparam int                    CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0]      DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(INST_BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_M = ~ADDR_WIDTH'(INST_BYTES - 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [INST_WIDTH-1:0] inst;
  } entry_t;

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0]      outstanding_q, outstanding_d;
  logic [CNT_W-1:0]      discard_q, discard_d;
  logic                  err_q, err_d;

  logic [CNT_W-1:0]      live;
  logic [CNT_W:0]        credit_sum;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_empty, fifo_full;
  logic                  req_valid, req_fire;
  logic                  rsp_unexp, rsp_ok, rsp_keep;
  logic                  fifo_pop;
  logic [ADDR_WIDTH-1:0] redirect_pc_aligned;
  entry_t                push_entry, head_entry;

  assign live                = outstanding_q - discard_q;
  assign credit_sum          = {1'b0, live} + {1'b0, fifo_count};
  assign redirect_pc_aligned = bus.redirect_pc & ALIGN_M;

  // fifo_full is implied by the credit check; kept so a full buffer never sees a request.
  assign req_valid = !rst && !bus.redirect_valid && !fifo_full
                     && (outstanding_q < DEPTH_C)
                     && (credit_sum < {1'b0, DEPTH_C});
  assign req_fire  = req_valid && bus.imem_req_ready;

  assign rsp_unexp = bus.imem_rsp_valid && (outstanding_q == '0);
  assign rsp_ok    = bus.imem_rsp_valid && (outstanding_q != '0);
  assign rsp_keep  = rsp_ok && !bus.redirect_valid && (discard_q == '0);

  assign fifo_pop  = bus.out_valid && bus.out_ready;

  assign push_entry = '{pc: rsp_pc_q, inst: bus.imem_rsp_inst};

  fetch_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (rsp_keep),
    .push_dat (push_entry),
    .pop      (fifo_pop),
    .pop_dat  (head_entry),
    .flush    (bus.redirect_valid),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.out_valid      = !rst && !fifo_empty;
  assign bus.out_pc         = head_entry.pc;
  assign bus.out_inst       = head_entry.inst;
  assign bus.err_rsp        = err_q;

  // Next PC, in-flight accounting and stale-stream tracking; redirect overrides.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    discard_d     = discard_q;
    err_d         = err_q || rsp_unexp;
    outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(rsp_ok);
    if (bus.redirect_valid) begin
      // Everything still in flight after this cycle belongs to the old stream.
      fetch_pc_d = redirect_pc_aligned;
      rsp_pc_d   = redirect_pc_aligned;
      discard_d  = outstanding_q - CNT_W'(rsp_ok);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + PC_STEP;
      end
      if (rsp_ok) begin
        if (discard_q != '0) begin
          discard_d = discard_q - CNT_W'(1);
        end else begin
          rsp_pc_d = rsp_pc_q + PC_STEP;
        end
      end
    end
  end

  // Fetch state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      err_q         <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      err_q         <= err_d;
    end
  end
endmodule

// File: tb/tb_rv_fetch_unit.sv
// Self-checking bench for rv_fetch_unit against a queue-based reference.
// Latency: n/a.
// Backpressure: randomized memory ready, decode ready and response latency.
module tb_rv_fetch_unit;
  import rv_fetch_unit_pkg::*;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] inst;
    bit          stale;
    int          due;
  } mem_ent_t;

  logic clk;
  logic rst;

  rv_fetch_unit_if #(.ADDR_WIDTH(32), .INST_WIDTH(32)) bus ();

  rv_fetch_unit #(
    .ADDR_WIDTH (32),
    .INST_WIDTH (32),
    .FIFO_DEPTH (DEPTH),
    .RESET_PC   (32'h0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests  = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference state: what memory holds in flight, what decode should see next.
  mem_ent_t     mem_q[$];
  fetch_entry_t fifo_q[$];
  logic [31:0]  m_fetch_pc;
  logic         m_err;
  int           lat      = 1;
  bit           lat_rand = 0;

  // Observations from the most recent cycle.
  logic        obs_req_vld, obs_out_vld, obs_err;
  logic [31:0] obs_req_addr, obs_out_pc;
  logic        acc_vld;
  logic [31:0] acc_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, compare DUT with the reference, advance the reference.
  task automatic step(input logic r, input logic rdy, input logic ordy,
                      input logic rd, input logic [31:0] rpc, input logic unsol);
    logic        rv;
    logic [31:0] ri;
    logic        exp_req, exp_out;
    int          live;
    mem_ent_t    h;
    mem_ent_t    n;
    @(negedge clk);
    rv = 1'b0;
    ri = '0;
    if (!r) begin
      if (unsol) begin
        rv = 1'b1;
        ri = $urandom;
      end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        rv = 1'b1;
        ri = mem_q[0].inst;
      end
    end
    rst                = r;
    bus.imem_req_ready = rdy;
    bus.imem_rsp_valid = rv;
    bus.imem_rsp_inst  = ri;
    bus.redirect_valid = rd;
    bus.redirect_pc    = rpc;
    bus.out_ready      = ordy;
    #1;
    live = 0;
    foreach (mem_q[i]) if (!mem_q[i].stale) live++;
    exp_req = !r && !rd && (mem_q.size() < DEPTH) && ((live + fifo_q.size()) < DEPTH);
    exp_out = !r && (fifo_q.size() > 0);
    check("req_valid", bus.imem_req_valid, exp_req);
    if (exp_req) check("req_addr", bus.imem_req_addr, m_fetch_pc);
    check("out_valid", bus.out_valid, exp_out);
    if (exp_out) begin
      check("out_pc", bus.out_pc, fifo_q[0].pc);
      check("out_inst", bus.out_inst, fifo_q[0].inst);
    end
    check("err_rsp", bus.err_rsp, m_err);
    obs_req_vld  = bus.imem_req_valid;
    obs_req_addr = bus.imem_req_addr;
    obs_out_vld  = bus.out_valid;
    obs_out_pc   = bus.out_pc;
    obs_err      = bus.err_rsp;
    acc_vld      = exp_req && rdy;
    acc_addr     = m_fetch_pc;
    if (r) begin
      mem_q.delete();
      fifo_q.delete();
      m_fetch_pc = 32'h0;
      m_err      = 1'b0;
    end else begin
      if (ordy && fifo_q.size() > 0) void'(fifo_q.pop_front());
      if (rv) begin
        if (mem_q.size() == 0) begin
          m_err = 1'b1;
        end else begin
          h = mem_q.pop_front();
          if (!rd && !h.stale) fifo_q.push_back('{pc: h.addr, inst: ri});
        end
      end
      check("fifo_bound", (fifo_q.size() <= DEPTH), 1'b1);
      if (rd) begin
        fifo_q.delete();
        foreach (mem_q[i]) mem_q[i].stale = 1'b1;
        m_fetch_pc = {rpc[31:2], 2'b00};
      end else if (acc_vld) begin
        n.addr  = m_fetch_pc;
        n.inst  = $urandom;
        n.stale = 1'b0;
        n.due   = cyc + (lat_rand ? int'($urandom_range(1, 4)) : lat);
        mem_q.push_back(n);
        m_fetch_pc = m_fetch_pc + INST_BYTES;
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  logic [31:0] acc_list[$];
  logic [31:0] exp_a[4];
  int          first_out, nout, found;
  logic [31:0] first_pc, got_a;

  initial begin
    rst = 1'b1;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_inst  = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b0;
    m_fetch_pc = 32'h0;
    m_err      = 1'b0;

    // Sequential fetch, single-cycle memory, decode always ready.
    lat_rand = 0; lat = 1;
    do_reset();
    check("rst_req_valid", obs_req_vld, 1'b0);
    check("rst_out_valid", obs_out_vld, 1'b0);
    check("rst_err", obs_err, 1'b0);
    acc_list.delete(); first_out = -1; nout = 0; first_pc = '1;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      if (acc_vld) acc_list.push_back(acc_addr);
      if (obs_out_vld) begin
        nout++;
        if (first_out < 0) begin first_out = i; first_pc = obs_out_pc; end
      end
    end
    exp_a = '{32'h0, 32'h4, 32'h8, 32'hC};
    check("p1_acc_count", acc_list.size(), 8);
    for (int i = 0; i < 4; i++) check("p1_addr", (acc_list.size() > i) ? acc_list[i] : 32'hDEAD_BEEF, exp_a[i]);
    check("p1_first_out_cycle", first_out, 2);
    check("p1_first_out_pc", first_pc, 32'h0);
    check("p1_out_count", nout, 6);

    // Decode stalled: buffer fills to four, then fetch resumes at 0x10.
    do_reset();
    acc_list.delete();
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      if (acc_vld) acc_list.push_back(acc_addr);
    end
    check("p2_acc_count", acc_list.size(), 4);
    check("p2_req_blocked", obs_req_vld, 1'b0);
    check("p2_head_valid", obs_out_vld, 1'b1);
    check("p2_head_pc", obs_out_pc, 32'h0);
    found = 0; got_a = '1;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      if (acc_vld && found == 0) begin found = 1; got_a = acc_addr; end
    end
    check("p2_resume_found", found, 1);
    check("p2_resume_addr", got_a, 32'h10);

    // Three-cycle memory, two in flight, redirect to 0x200.
    do_reset();
    lat = 3;
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h200, 1'b0);
    acc_list.delete(); first_pc = '1; first_out = -1;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      if (acc_vld) acc_list.push_back(acc_addr);
      if (obs_out_vld && first_out < 0) begin first_out = i; first_pc = obs_out_pc; end
    end
    check("p3_addr0", (acc_list.size() > 0) ? acc_list[0] : 32'hDEAD_BEEF, 32'h200);
    check("p3_addr1", (acc_list.size() > 1) ? acc_list[1] : 32'hDEAD_BEEF, 32'h204);
    check("p3_first_out_pc", first_pc, 32'h200);

    // Misaligned redirect target is forced to a word boundary.
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h103, 1'b0);
    acc_list.delete(); first_pc = '1; first_out = -1;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      if (acc_vld) acc_list.push_back(acc_addr);
      if (obs_out_vld && first_out < 0) begin first_out = i; first_pc = obs_out_pc; end
    end
    check("p4_addr0", (acc_list.size() > 0) ? acc_list[0] : 32'hDEAD_BEEF, 32'h100);
    check("p4_first_out_pc", first_pc, 32'h100);

    // Redirect colliding with a response and a decode pop.
    lat = 1;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      if (mem_q.size() > 0 && mem_q[0].due <= cyc && fifo_q.size() > 0) found = 1;
      else step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    end
    check("p5_collision_found", found, 1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h300, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    check("p5_flushed", obs_out_vld, 1'b0);
    check("p5_next_addr", acc_vld ? acc_addr : 32'hDEAD_BEEF, 32'h300);

    // Reset mid-stream with buffered and in-flight fetches, then an unsolicited response.
    do_reset();
    lat = 6;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check("p6_buffered", obs_out_vld, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("p6_rst_req_valid", obs_req_vld, 1'b0);
    check("p6_rst_out_valid", obs_out_vld, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("p6_first_req_valid", obs_req_vld, 1'b1);
    check("p6_first_req_addr", obs_req_addr, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("p6_err_sticky", obs_err, 1'b1);

    // Randomized traffic against the reference.
    lat_rand = 1;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 24) == 0),
           $urandom, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
